// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: turns 32-bit word-read requests into SPI flash READ transactions on the spi_mst register port.
// Define FAST_READ_EN to use the fast-read opcode (0x0B) with one dummy byte after the address.
module spi_flash_rd_seq #(
`ifdef FAST_READ_EN
   parameter logic [7:0] CMD_FAST = 8'h0B,
`endif
   parameter logic [4:0] TX_REG   = 5'h00,
   parameter logic [4:0] RX_REG   = 5'h04,
   parameter logic [4:0] CS_REG   = 5'h08,
   parameter logic [7:0] CMD_READ = 8'h03
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [23:0] req_addr_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        hs_read_o,
   output logic        hs_write_o,
   output logic [4:0]  hs_addr_o,
   output logic [7:0]  hs_data_o,
   input  logic        hs_ready_i,
   input  logic [7:0]  hs_data_i
);
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_CS_ON   = 4'd1;
   localparam logic [3:0] S_CMD     = 4'd2;
   localparam logic [3:0] S_ADDR    = 4'd3;
`ifdef FAST_READ_EN
   localparam logic [3:0] S_DUMMY   = 4'd4;
   localparam logic [3:0] S_AFTER_A = S_DUMMY;
   localparam logic [7:0] W_CMD     = CMD_FAST;
`else
   localparam logic [3:0] S_AFTER_A = 4'd5;
   localparam logic [7:0] W_CMD     = CMD_READ;
`endif
   localparam logic [3:0] S_DATA_TX = 4'd5;
   localparam logic [3:0] S_DATA_RX = 4'd6;
   localparam logic [3:0] S_CS_OFF  = 4'd7;
   localparam logic [3:0] S_RESP    = 4'd8;

   logic [3:0]  r_state;
   logic [1:0]  r_cnt;
   logic [23:0] r_addr;
   logic [31:0] r_data;
   logic        r_rd;
   logic        r_wr;
   logic [4:0]  r_hs_addr;
   logic [7:0]  r_hs_data;
   logic [7:0]  w_addr_byte;
   logic        w_op_rd;
   logic [4:0]  w_op_addr;
   logic [7:0]  w_op_data;
   logic [3:0]  w_next;
   logic [1:0]  w_cnt_next;

   assign req_ready_o = r_state == S_IDLE;
   assign rsp_valid_o = r_state == S_RESP;
   assign rsp_data_o  = r_data;
   assign hs_read_o   = r_rd;
   assign hs_write_o  = r_wr;
   assign hs_addr_o   = r_hs_addr;
   assign hs_data_o   = r_hs_data;

   always_comb begin
      w_addr_byte = (r_cnt == 2'd0) ? r_addr[23:16] : (r_cnt == 2'd1) ? r_addr[15:8] : r_addr[7:0];
      w_op_rd     = r_state == S_DATA_RX;
      w_op_addr   = (r_state == S_CS_ON || r_state == S_CS_OFF) ? CS_REG : w_op_rd ? RX_REG : TX_REG;
      w_op_data   = (r_state == S_CS_ON) ? 8'h01 : (r_state == S_CMD) ? W_CMD :
                    (r_state == S_ADDR) ? w_addr_byte : 8'h00;
      w_cnt_next  = (r_state == S_ADDR && r_cnt == 2'd2) ? 2'd0 :
                    (r_state == S_ADDR || r_state == S_DATA_RX) ? r_cnt + 2'd1 : r_cnt;
      w_next      = r_state;
      case (r_state)
         S_CS_ON:   w_next = S_CMD;
         S_CMD:     w_next = S_ADDR;
         S_ADDR:    w_next = (r_cnt == 2'd2) ? S_AFTER_A : S_ADDR;
`ifdef FAST_READ_EN
         S_DUMMY:   w_next = S_DATA_TX;
`endif
         S_DATA_TX: w_next = S_DATA_RX;
         S_DATA_RX: w_next = (r_cnt == 2'd3) ? S_CS_OFF : S_DATA_TX;
         S_CS_OFF:  w_next = S_RESP;
         default:   w_next = r_state;
      endcase
   end

   // An op is issued from a state with no strobe up, so one idle cycle always separates ops.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_cnt     <= 2'd0;
         r_addr    <= 24'h0;
         r_data    <= 32'h0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_hs_addr <= 5'h0;
         r_hs_data <= 8'h0;
      end else if (r_state == S_IDLE) begin
         if (req_valid_i) begin
            r_addr  <= req_addr_i;
            r_data  <= 32'h0;
            r_cnt   <= 2'd0;
            r_state <= S_CS_ON;
         end
      end else if (r_state == S_RESP) begin
         if (rsp_ready_i) r_state <= S_IDLE;
      end else if (!r_rd && !r_wr) begin
         r_rd      <= w_op_rd;
         r_wr      <= !w_op_rd;
         r_hs_addr <= w_op_addr;
         r_hs_data <= w_op_data;
      end else if (hs_ready_i) begin
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         if (w_op_rd) r_data[{r_cnt, 3'b000} +: 8] <= hs_data_i;
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end
endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// tb_spi_flash_rd_seq: directed bench with a behavioural spi_mst and SPI flash model.
`timescale 1ns/1ps
module tb_spi_flash_rd_seq;
`ifdef FAST_READ_EN
   localparam int HDR = 5;
   localparam logic [7:0] CMD = 8'h0B;
`else
   localparam int HDR = 4;
   localparam logic [7:0] CMD = 8'h03;
`endif
   localparam int NOPS = HDR + 10;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [23:0] req_addr_i = 24'h0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_data_o;
   logic        hs_read_o;
   logic        hs_write_o;
   logic [4:0]  hs_addr_o;
   logic [7:0]  hs_data_o;
   logic        hs_ready_i = 1'b0;
   logic [7:0]  hs_data_i = 8'h0;

   int          n_vec = 0;
   int          n_err = 0;
   int          delay = 1;
   bit          spur = 1'b0;
   bit          pend = 1'b0;
   bit          p_rd;
   logic [4:0]  p_addr;
   logic [7:0]  p_data;
   int          p_wait;
   bit          cs = 1'b0;
   int          nbytes = 0;
   logic [7:0]  f_cmd = 8'h0;
   logic [7:0]  miso = 8'h0;
   logic [23:0] f_addr = 24'h0;
   logic [13:0] oplog[$];
   int          viol_hs = 0;
   int          viol_acc = 0;
   bit          outst = 1'b0;
   time         t_acc;

   spi_flash_rd_seq dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
      .hs_read_o(hs_read_o), .hs_write_o(hs_write_o), .hs_addr_o(hs_addr_o), .hs_data_o(hs_data_o),
      .hs_ready_i(hs_ready_i), .hs_data_i(hs_data_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] fbyte(input logic [23:0] a);
      case (a)
         24'h10:  return 8'h11;
         24'h11:  return 8'h22;
         24'h12:  return 8'h33;
         24'h13:  return 8'h44;
         default: return a[7:0] ^ a[15:8] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [13:0] exp_op(input int i, input logic [23:0] a);
      if (i == 0) return {1'b0, 5'h08, 8'h01};
      if (i == 1) return {1'b0, 5'h00, CMD};
      if (i <= 4) return {1'b0, 5'h00, (i == 2) ? a[23:16] : (i == 3) ? a[15:8] : a[7:0]};
      if (i <= HDR) return {1'b0, 5'h00, 8'h00};
      if (i == NOPS - 1) return {1'b0, 5'h08, 8'h00};
      return ((i - HDR - 1) % 2 == 0) ? {1'b0, 5'h00, 8'h00} : {1'b1, 5'h04, 8'h00};
   endfunction

   // spi_mst answers each op after `delay` cycles; the flash sits behind it.
   always @(negedge clk) begin
      hs_ready_i = 1'b0;
      if (hs_read_o && hs_write_o) viol_hs++;
      if (rst_i) begin
         pend = 1'b0; cs = 1'b0; nbytes = 0; outst = 1'b0;
      end else begin
         if (req_valid_i && req_ready_o) begin
            if (outst) viol_acc++;
            outst = 1'b1;
         end
         if (rsp_valid_o && rsp_ready_i) outst = 1'b0;
         if ((hs_read_o || hs_write_o) && !pend) begin
            pend = 1'b1; p_wait = 0; p_rd = hs_read_o; p_addr = hs_addr_o; p_data = hs_data_o;
         end
         if (pend) begin
            if (hs_read_o !== p_rd || hs_write_o !== !p_rd || hs_addr_o !== p_addr || hs_data_o !== p_data) viol_hs++;
            p_wait++;
            if (p_wait >= delay) begin
               pend = 1'b0;
               hs_ready_i = 1'b1;
               oplog.push_back({p_rd, p_addr, p_rd ? 8'h00 : p_data});
               if (p_rd) hs_data_i = miso;
               else if (p_addr == 5'h08) begin
                  cs = p_data == 8'h01; nbytes = 0;
               end else if (cs) begin
                  if (nbytes == 0) f_cmd = p_data;
                  else if (nbytes <= 3) f_addr = {f_addr[15:0], p_data};
                  miso = (nbytes >= HDR) ? fbyte(f_addr + 24'(nbytes - HDR)) : 8'hFF;
                  nbytes++;
                  hs_data_i = miso;
               end
            end
         end else if (spur && req_ready_o) begin
            hs_ready_i = 1'b1;
            hs_data_i = 8'hA5;
         end
      end
   end

   task automatic wait_accept();
      int n = 0;
      do begin @(negedge clk); n++; end while (!(req_valid_i && req_ready_o) && n < 5000);
      if (n >= 5000) chk("accept_timeout", 32'd0, 32'd1);
      t_acc = $time;
      @(posedge clk);
      oplog.delete();
   endtask

   task automatic collect(input logic [23:0] a, input int bp, input logic [31:0] exp, input bit lat);
      int n = 0;
      int bad = 0;
      logic [31:0] d;
      do begin @(negedge clk); n++; end while (!rsp_valid_o && n < 5000);
      chk("rsp_valid", {31'h0, rsp_valid_o}, 32'd1);
      if (lat) chk("latency", int'(($time - t_acc) / 10), 2 * NOPS + 1);
      d = rsp_data_o;
      chk("rsp_data", d, exp);
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         if (!rsp_valid_o || rsp_data_o !== d || req_ready_o) bad++;
      end
      if (bp > 0) chk("bp_hold", bad, 0);
      @(posedge clk); #1 rsp_ready_i = 1'b1;
      @(negedge clk); chk("rsp_hold", {31'h0, rsp_valid_o}, 32'd1);
      @(posedge clk); #1 rsp_ready_i = 1'b0;
      chk("rdy_after", {31'h0, req_ready_o}, 32'd1);
      chk("valid_after", {31'h0, rsp_valid_o}, 32'd0);
      chk("nops", oplog.size(), NOPS);
      for (int i = 0; i < oplog.size() && i < NOPS; i++) chk($sformatf("op%0d", i), {18'h0, oplog[i]}, {18'h0, exp_op(i, a)});
      chk("flash_cmd", {24'h0, f_cmd}, {24'h0, CMD});
      chk("flash_addr", {8'h0, f_addr}, {8'h0, a});
   endtask

   task automatic do_read(input logic [23:0] a, input int bp, input logic [31:0] exp, input bit lat);
      @(posedge clk); #1 req_valid_i = 1'b1; req_addr_i = a;
      wait_accept();
      #1 req_valid_i = 1'b0;
      collect(a, bp, exp, lat);
   endtask

   initial begin
      int n;
      #12;
      chk("reset_outs", {15'h0, req_ready_o, rsp_valid_o, hs_read_o, hs_write_o, hs_addr_o, hs_data_o}, 32'h10000);
      chk("reset_data", rsp_data_o, 32'h0);
      @(negedge clk); #1 rst_i = 1'b0;

      do_read(24'h000010, 0, 32'h44332211, 1'b1);
      do_read(24'h000100, 20, 32'h58595A5B, 1'b1);
      delay = 37;
      do_read(24'h000200, 0, 32'h5B5A5958, 1'b0);

      delay = 10;
      @(posedge clk); #1 req_valid_i = 1'b1; req_addr_i = 24'h123456;
      wait_accept();
      #1 req_valid_i = 1'b0;
      n = 0;
      do begin @(negedge clk); #2; n++; end while (!(pend && oplog.size() == 3) && n < 2000);
      chk("pre_rst_byte", {23'h0, hs_write_o, hs_data_o}, 32'h134);
      rst_i = 1'b1;
      #1;
      chk("async_rst_outs", {15'h0, req_ready_o, rsp_valid_o, hs_read_o, hs_write_o, hs_addr_o, hs_data_o}, 32'h10000);
      chk("async_rst_data", rsp_data_o, 32'h0);
      repeat (2) @(negedge clk);
      #1 rst_i = 1'b0;
      delay = 1;
      do_read(24'hFFFFFC, 0, 32'h5A5B5859, 1'b1);

      spur = 1'b1;
      repeat (3) @(posedge clk);
      chk("spur_idle", {30'h0, hs_read_o, hs_write_o}, 32'd0);
      #1 req_valid_i = 1'b1; req_addr_i = 24'h000010;
      wait_accept();
      #1 req_addr_i = 24'h000100;
      collect(24'h000010, 0, 32'h44332211, 1'b1);
      wait_accept();
      #1 req_valid_i = 1'b0;
      collect(24'h000100, 0, 32'h58595A5B, 1'b1);
      spur = 1'b0;

      chk("hs_protocol", viol_hs, 0);
      chk("early_accept", viol_acc, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/spi_flash_rd_seq.md
Name: spi_flash_rd_seq

Overview:
Sequencer that turns 32-bit word-read requests into SPI flash READ transactions by driving the spi_mst register/handshake port, the same port the AXI slave bridge drives. Sits between an instruction/data fetch requester and one spi_mst instance. It has sole ownership of that instance while instantiated. Response bytes are assembled little-endian: first flash byte goes to bits [7:0].

Parameters:
TX_REG, 5'h00, spi_mst offset; a write sends hs_data byte on MOSI, and the received MISO byte becomes readable.
RX_REG, 5'h04, spi_mst offset; a read returns the last received byte.
CS_REG, 5'h08, spi_mst offset; write 8'h01 asserts cs_no low, write 8'h00 deasserts it.
CMD_READ, 8'h03, flash read opcode (normal mode).
CMD_FAST, 8'h0B, flash fast-read opcode (FAST_READ_EN only).

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  asynchronous, active-high reset
req_valid_i  input  1  read request valid
req_ready_o  output  1  request accepted when valid&&ready
req_addr_i  input  24  flash byte address
rsp_valid_o  output  1  read data valid
rsp_ready_i  input  1  consumer accepts data
rsp_data_o  output  32  assembled word
hs_read_o  output  1  spi_mst register read strobe
hs_write_o  output  1  spi_mst register write strobe
hs_addr_o  output  5  spi_mst register offset
hs_data_o  output  8  spi_mst write data
hs_ready_i  input  1  spi_mst op complete (1-cycle pulse)
hs_data_i  input  8  spi_mst read data, valid when hs_ready_i=1

Behaviour:
- Reset (async, any state): state=IDLE; req_ready_o=1; rsp_valid_o=0; rsp_data_o=0; hs_read_o=hs_write_o=0; hs_addr_o=0; hs_data_o=0; byte counter=0. A reset mid-transaction abandons it. No CS_REG deassert is issued; spi_mst shares the reset.
- Handshake to spi_mst: assert hs_read_o or hs_write_o with stable hs_addr_o/hs_data_o. Hold until the cycle where hs_ready_i=1, then drop it on the next edge. There is at least one idle cycle between ops. hs_read_o and hs_write_o are never both high. hs_ready_i is ignored when no op is outstanding.
- req_ready_o=1 only in IDLE. On accept, latch req_addr_i, clear the data register and go to CS_ON.
- States and op sequence, each advancing on hs_ready_i:
  - IDLE
  - CS_ON: write CS_REG=8'h01
  - CMD: write TX_REG=CMD_READ
  - ADDR: write TX_REG with addr[23:16], then [15:8], then [7:0]; 2-bit counter 0..2
  - DATA_TX: write TX_REG=8'h00
  - DATA_RX: read RX_REG; on hs_ready_i, store hs_data_i into byte lane[counter]. Counter 0..3 loops DATA_TX/DATA_RX; after lane 3 go to CS_OFF.
  - CS_OFF: write CS_REG=8'h00
  - RESP
- Total of 14 spi_mst ops per request in normal mode.
- RESP: rsp_valid_o=1 with rsp_data_o stable until rsp_ready_i=1. Then go to IDLE with req_ready_o=1 on the next cycle. A new request is never accepted before the response handshake completes.
- rsp_ready_i high while rsp_valid_o=0 has no effect. req_valid_i outside IDLE is ignored and not queued.
- Address wrap: no increment is performed. Address 24'hFFFFFF is sent verbatim; the flash device handles wrap.
- Minimum request-to-response latency is 2 cycles per op plus 1 cycle (spi_mst with 1-cycle ready); actual latency scales with the spi_mst SCK period.

Optional Feature:
FAST_READ_EN
- Defined: CMD writes CMD_FAST. A DUMMY state after ADDR writes TX_REG=8'h00 once and discards the result. Sequence is 15 ops.
- Undefined: CMD_READ is used, with no DUMMY state and no CMD_FAST logic.

Test Plan:
- Bench setup: behavioural spi_mst model (ready after N cycles) plus a flash model.
- Basic read: req addr 24'h000010, flash bytes 10..13 = 11,22,33,44 -> hs write sequence CS=01,03,00,00,10,(00,rdRX)x4,CS=00; rsp_data_o=32'h44332211.
- Backpressure: rsp_ready_i held low 20 cycles -> rsp_valid_o and data stable, req_ready_o=0 throughout; accept on cycle 21, then req_ready_o=1 the next cycle.
- Slow spi_mst: hs_ready_i delayed 37 cycles per op -> strobes and hs_addr_o/hs_data_o held stable the whole time, never both strobes high.
- Reset mid-transaction: assert rst_i during ADDR byte 1 -> all outputs at reset values immediately (async); a following request to 24'hFFFFFC completes normally, addr bytes FF,FF,FC.
- Back-to-back: req_valid_i held high with 2 addresses -> second accepted only after the first rsp handshake; spurious hs_ready_i pulses in IDLE ignored.
- FAST_READ_EN build: addr 24'h000100 -> opcode 0B, one dummy TX write, 15 ops total, data correct.
